// File: rtl/vpu_seq_pkg.sv
// vpu_seq_pkg: opcodes, instruction layout and sequencer states shared by the sequencer and its bench.
package vpu_seq_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int OP_LSB = 28, FLAGS_LSB = 24, CNT_LSB = 16, ADDR_LSB = 0;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_CTRL = 4'h1, OP_CLR = 4'h2, OP_LDL = 4'h3, OP_LDT = 4'h4,
    OP_STORE = 4'h5, OP_WAIT = 4'h6, OP_JUMP = 4'h7, OP_LOOP = 4'h8, OP_HALT = 4'hF
  } opcode_t;
  typedef struct packed {
    opcode_t     op;
    logic [3:0]  flags;
    logic [7:0]  cnt;
    logic [15:0] addr;
  } instr_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_LOAD, S_STORE, S_WAIT} seq_state_t;
  function automatic logic [INSTR_WIDTH-1:0] mk_instr(logic [3:0] op, logic [3:0] flags, logic [7:0] cnt, logic [15:0] addr);
    return (32'(op) << OP_LSB) | (32'(flags) << FLAGS_LSB) | (32'(cnt) << CNT_LSB) | (32'(addr) << ADDR_LSB);
  endfunction
endpackage

// File: rtl/vpu_seq_if.sv
// vpu_seq_if: sequencer bundle toward instr mem, DPRAM port A and the systolic array.
interface vpu_seq_if import vpu_seq_pkg::*; #(
  parameter int DATA_WIDTH = 8, MATRIX_SIZE = 8, ACC_WIDTH = 32, DP_ADDR_WIDTH = 10, INSTR_DEPTH = 256
);
  localparam int PCW = $clog2(INSTR_DEPTH), NW = $clog2(MATRIX_SIZE), AW = $clog2(MATRIX_SIZE * MATRIX_SIZE);
  logic start, busy, done, err;
  logic [PCW-1:0] rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [DP_ADDR_WIDTH-1:0] dp_addr;
  logic dp_we;
  logic [DATA_WIDTH-1:0] dp_din, dp_dout;
  logic load_en_left, load_en_top;
  logic [NW-1:0] addr_left, addr_top;
  logic [DATA_WIDTH-1:0] data_in_left, data_in_top;
  logic swap_buffers_left, swap_buffers_top, buffer_rst_left, buffer_rst_top;
  logic acc_rst, acc_en, shift_en_right, shift_en_down;
  logic [AW-1:0] addr_acc;
  logic [ACC_WIDTH-1:0] acc_out;
  modport master (
    input start, rd_data, dp_dout, acc_out,
    output busy, done, err, rd_addr, dp_addr, dp_we, dp_din, load_en_left, load_en_top,
    addr_left, addr_top, data_in_left, data_in_top, swap_buffers_left, swap_buffers_top,
    buffer_rst_left, buffer_rst_top, acc_rst, acc_en, shift_en_right, shift_en_down, addr_acc
  );
  modport slave (
    output start, rd_data, dp_dout, acc_out,
    input busy, done, err, rd_addr, dp_addr, dp_we, dp_din, load_en_left, load_en_top,
    addr_left, addr_top, data_in_left, data_in_top, swap_buffers_left, swap_buffers_top,
    buffer_rst_left, buffer_rst_top, acc_rst, acc_en, shift_en_right, shift_en_down, addr_acc
  );
endinterface

// File: rtl/vpu_seq_ctrl_acc_store_serializer.sv
// acc_store_serializer: walks every accumulator byte lane in little-endian order onto DPRAM port A.
module acc_store_serializer #(
  parameter int DW = 8, N = 8, ACCW = 32, DPW = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go_i,
  input  logic [DPW-1:0]            base_i,
  input  logic [ACCW-1:0]           acc_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      we_o,
  output logic [DPW-1:0]            addr_o,
  output logic [DW-1:0]             din_o,
  output logic [$clog2(N*N)-1:0]    acc_sel_o
);
  localparam int B = ACCW / DW, BW = B > 1 ? $clog2(B) : 1, AW = $clog2(N * N);
  logic [AW-1:0] i_q, i_d;
  logic [BW-1:0] b_q, b_d;
  logic [DPW-1:0] a_q, a_d;
  logic run_q, run_d, last_b, last;
  assign last_b = b_q == BW'(B - 1);
  assign last = run_q && last_b && i_q == AW'(N * N - 1);
  always_comb begin
    run_d = go_i | (run_q & ~last);
    i_d = go_i ? '0 : (run_q && last_b) ? i_q + 1'b1 : i_q;
    b_d = (go_i || last_b) ? '0 : run_q ? b_q + 1'b1 : b_q;
    a_d = go_i ? base_i : a_q + DPW'(run_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q <= 1'b0;
      i_q <= '0;
      b_q <= '0;
      a_q <= '0;
    end else begin
      run_q <= run_d;
      i_q <= i_d;
      b_q <= b_d;
      a_q <= a_d;
    end
  end
  assign busy_o = run_q;
  assign we_o = run_q;
  assign done_o = last;
  assign addr_o = run_q ? a_q : '0;
  assign din_o = run_q ? acc_i[b_q*DW +: DW] : '0;
  assign acc_sel_o = i_q;
endmodule

// File: rtl/vpu_seq_ctrl.sv
// vpu_seq_ctrl: microcoded systolic-array sequencer; defining VPU_SEQ_LOOP_EN adds the one-level LOOP op.
module vpu_seq_ctrl import vpu_seq_pkg::*; #(
  parameter int DATA_WIDTH = 8, MATRIX_SIZE = 8, ACC_WIDTH = 32, DP_ADDR_WIDTH = 10, INSTR_DEPTH = 256
) (
  input logic clk,
  input logic rst,
  vpu_seq_if.master bus
);
  localparam int PCW = $clog2(INSTR_DEPTH), NW = $clog2(MATRIX_SIZE), LW = $clog2(MATRIX_SIZE + 1);
  seq_state_t st_q, st_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, le_q, le_d, top_q, top_d;
  logic [DP_ADDR_WIDTH-1:0] la_q, la_d, s_addr;
  logic [LW-1:0] k_q, k_d;
  logic [NW-1:0] ba_q, ba_d;
  logic [7:0] w_q, w_d;
  logic s_go, s_busy, s_done, ex, ctrl, clr, unused_addr;
  instr_t ins;
`ifdef VPU_SEQ_LOOP_EN
  logic [7:0] lc_q, lc_d, lc_eff;
  logic arm_q, arm_d;
  assign lc_eff = arm_q ? lc_q : ins.cnt;
`endif
  assign ins = instr_t'(bus.rd_data);
  assign unused_addr = ^ins.addr;
  assign ex = st_q == S_EXEC;
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    la_d = la_q;
    k_d = k_q;
    le_d = 1'b0;
    ba_d = ba_q;
    top_d = top_q;
    w_d = w_q;
    s_go = 1'b0;
`ifdef VPU_SEQ_LOOP_EN
    lc_d = lc_q;
    arm_d = arm_q;
`endif
    case (st_q)
      // done_q marks the cycle HALT retires; a start there is dropped
      S_IDLE: if (bus.start && !done_q) begin
        st_d = S_FETCH;
        pc_d = '0;
        busy_d = 1'b1;
        err_d = 1'b0;
`ifdef VPU_SEQ_LOOP_EN
        arm_d = 1'b0;
`endif
      end
      S_FETCH: st_d = S_EXEC;
      S_EXEC: begin
        st_d = S_FETCH;
        pc_d = pc_q + 1'b1;
        case (ins.op)
          OP_NOP, OP_CTRL, OP_CLR: ;
          OP_LDL, OP_LDT: begin
            st_d = S_LOAD;
            la_d = ins.addr[DP_ADDR_WIDTH-1:0];
            k_d = '0;
            top_d = ins.op == OP_LDT;
          end
          OP_STORE: begin
            st_d = S_STORE;
            s_go = 1'b1;
          end
          OP_WAIT: begin
            w_d = ins.cnt;
            st_d = |ins.cnt ? S_WAIT : S_FETCH;
          end
          OP_JUMP: pc_d = ins.addr[PCW-1:0];
`ifdef VPU_SEQ_LOOP_EN
          OP_LOOP: begin
            lc_d = lc_eff - 1'b1;
            arm_d = |lc_eff;
            pc_d = |lc_eff ? ins.addr[PCW-1:0] : pc_q + 1'b1;
          end
`endif
          OP_HALT: begin
            st_d = S_IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
          default: begin
            st_d = S_IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
            err_d = 1'b1;
          end
        endcase
      end
      // burst cycle k issues address k; the byte lands in the buffer one cycle later
      S_LOAD: if (k_q == LW'(MATRIX_SIZE)) st_d = S_FETCH;
      else begin
        le_d = 1'b1;
        ba_d = NW'(k_q);
        la_d = la_q + 1'b1;
        k_d = k_q + 1'b1;
      end
      S_STORE: if (s_done) st_d = S_FETCH;
      S_WAIT: begin
        w_d = w_q - 1'b1;
        if (w_q == 8'd1) st_d = S_FETCH;
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= S_IDLE;
      pc_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      la_q <= '0;
      k_q <= '0;
      le_q <= 1'b0;
      ba_q <= '0;
      top_q <= 1'b0;
      w_q <= '0;
`ifdef VPU_SEQ_LOOP_EN
      lc_q <= '0;
      arm_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      la_q <= la_d;
      k_q <= k_d;
      le_q <= le_d;
      ba_q <= ba_d;
      top_q <= top_d;
      w_q <= w_d;
`ifdef VPU_SEQ_LOOP_EN
      lc_q <= lc_d;
      arm_q <= arm_d;
`endif
    end
  end
  acc_store_serializer #(.DW(DATA_WIDTH), .N(MATRIX_SIZE), .ACCW(ACC_WIDTH), .DPW(DP_ADDR_WIDTH)) u_ser (
    .clk(clk), .rst(rst), .go_i(s_go), .base_i(ins.addr[DP_ADDR_WIDTH-1:0]), .acc_i(bus.acc_out),
    .busy_o(s_busy), .done_o(s_done), .we_o(bus.dp_we), .addr_o(s_addr), .din_o(bus.dp_din),
    .acc_sel_o(bus.addr_acc)
  );
  assign ctrl = ex && ins.op == OP_CTRL;
  assign clr = ex && ins.op == OP_CLR;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.rd_addr = pc_q;
  assign bus.dp_addr = s_busy ? s_addr : (st_q == S_LOAD && k_q != LW'(MATRIX_SIZE)) ? la_q : '0;
  assign bus.load_en_left = le_q & ~top_q;
  assign bus.load_en_top = le_q & top_q;
  assign bus.addr_left = bus.load_en_left ? ba_q : '0;
  assign bus.addr_top = bus.load_en_top ? ba_q : '0;
  assign bus.data_in_left = bus.load_en_left ? bus.dp_dout : '0;
  assign bus.data_in_top = bus.load_en_top ? bus.dp_dout : '0;
  assign bus.swap_buffers_left = ctrl & ins.flags[3];
  assign bus.swap_buffers_top = ctrl & ins.flags[2];
  assign bus.shift_en_right = ctrl & ins.flags[1];
  assign bus.shift_en_down = ctrl & ins.flags[0];
  assign bus.acc_en = ctrl & ins.cnt[0];
  assign bus.acc_rst = clr & ins.flags[2];
  assign bus.buffer_rst_top = clr & ins.flags[1];
  assign bus.buffer_rst_left = clr & ins.flags[0];
endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// tb_vpu_seq_ctrl: scoreboard bench for vpu_seq_ctrl with behavioural instr mem, DPRAM and accumulators.
module tb_vpu_seq_ctrl;
  import vpu_seq_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  vpu_seq_if bus ();
  vpu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] imem [256];
  logic [7:0] dpram [1024];
  logic [31:0] acc [64];
  always @(posedge clk) begin
    bus.rd_data <= imem[bus.rd_addr];
    bus.dp_dout <= dpram[bus.dp_addr];
    if (bus.dp_we) dpram[bus.dp_addr] <= bus.dp_din;
  end
  assign bus.acc_out = acc[bus.addr_acc];
  logic [67:0] outs;
  assign outs = {bus.busy, bus.done, bus.err, bus.rd_addr, bus.dp_addr, bus.dp_we, bus.dp_din,
    bus.load_en_left, bus.load_en_top, bus.addr_left, bus.addr_top, bus.data_in_left, bus.data_in_top,
    bus.swap_buffers_left, bus.swap_buffers_top, bus.buffer_rst_left, bus.buffer_rst_top,
    bus.acc_rst, bus.acc_en, bus.shift_en_right, bus.shift_en_down, bus.addr_acc};
  int n_chk = 0, n_fail = 0;
  int c_busy, c_done, c_done_busy, c_sl, c_st, c_sr, c_sd, c_ae, c_ar, c_brt, c_brl;
  bit timed_out, hold_start;
  logic err_done, err0;
  logic [7:0] rd0;
  localparam logic [31:0] HALT = 32'hF000_0000;

  task automatic clr_imem;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) imem[i] = HALT;
  endtask

  task automatic run_collect(input int limit);
    {c_busy, c_done, c_done_busy, c_sl, c_st, c_sr, c_sd, c_ae, c_ar, c_brt, c_brl} = '0;
    timed_out = 1'b1;
    bus.start = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (!hold_start) bus.start = 1'b0;
      if (c == 0) begin rd0 = bus.rd_addr; err0 = bus.err; end
      c_busy += int'(bus.busy);
      c_sl += int'(bus.swap_buffers_left);
      c_st += int'(bus.swap_buffers_top);
      c_sr += int'(bus.shift_en_right);
      c_sd += int'(bus.shift_en_down);
      c_ae += int'(bus.acc_en);
      c_ar += int'(bus.acc_rst);
      c_brt += int'(bus.buffer_rst_top);
      c_brl += int'(bus.buffer_rst_left);
      if (bus.done) begin
        c_done++;
        if (bus.busy) c_done_busy++;
        err_done = bus.err;
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", outs); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL idle_outputs got %h exp 0", outs); end
  endtask

  task automatic test_load_top;
    logic [9:0] q_a[$], prev_a, ea, a;
    logic [10:0] q_d[$], ed;
    int nle = 0, nll = 0;
    bit fin = 1'b0;
    clr_imem();
    imem[0] = mk_instr(OP_LDT, 4'h0, 8'h00, 16'h03FE);
    for (int i = 0; i < 1024; i++) dpram[i] = 8'(i) ^ 8'hA5;
    for (int k = 0; k < 8; k++) begin
      a = 10'(32'h3FE + k);
      q_a.push_back(a);
      q_d.push_back({3'(k), a[7:0] ^ 8'hA5});
    end
    prev_a = '0;
    bus.start = 1'b1;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.load_en_left) nll++;
      if (bus.load_en_top) begin
        nle++;
        n_chk++;
        if (q_a.size() == 0) begin n_fail++; $display("FAIL load_extra addr_top=%0d", bus.addr_top); end
        else begin
          ea = q_a.pop_front();
          ed = q_d.pop_front();
          if (prev_a !== ea) begin n_fail++; $display("FAIL load_dp_addr got %h exp %h", prev_a, ea); end
          n_chk++;
          if ({bus.addr_top, bus.data_in_top} !== ed) begin
            n_fail++; $display("FAIL load_data got addr %0d data %h exp addr %0d data %h", bus.addr_top, bus.data_in_top, ed[10:8], ed[7:0]);
          end
        end
      end
      if (bus.done) fin = 1'b1;
      prev_a = bus.dp_addr;
    end
    n_chk++; if (!fin) begin n_fail++; $display("FAIL load_timeout done not seen"); end
    n_chk++; if (nle != 8 || nll != 0) begin n_fail++; $display("FAIL load_count top %0d left %0d exp 8 0", nle, nll); end
    n_chk++; if (q_a.size() != 0) begin n_fail++; $display("FAIL load_missing %0d beats", q_a.size()); end
  endtask

  task automatic test_reset_mid_load;
    int nle = 0, nwe = 0, nb = 0;
    bit seen = 1'b0;
    clr_imem();
    imem[0] = mk_instr(OP_LDT, 4'h0, 8'h00, 16'h0040);
    bus.start = 1'b1;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      seen = bus.load_en_top;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL midrst_timeout no load_en"); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL midrst_outputs got %h exp 0", outs); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nle += int'(bus.load_en_top | bus.load_en_left);
      nwe += int'(bus.dp_we);
      nb += int'(bus.busy);
    end
    n_chk++; if (nle + nwe + nb != 0) begin n_fail++; $display("FAIL midrst_after load_en %0d we %0d busy %0d exp 0", nle, nwe, nb); end
  endtask

  task automatic test_store;
    logic [17:0] q[$], e;
    int nwe = 0;
    bit fin = 1'b0;
    clr_imem();
    imem[0] = mk_instr(OP_STORE, 4'h0, 8'h00, 16'h0100);
    for (int i = 0; i < 64; i++) acc[i] = 32'h1122_3300 + 32'(i);
    for (int i = 0; i < 1024; i++) dpram[i] = 8'h00;
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) q.push_back({10'(32'h100 + i * 4 + b), 8'((32'h1122_3300 + i) >> (8 * b))});
    bus.start = 1'b1;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.dp_we) begin
        nwe++;
        n_chk++;
        if (q.size() == 0) begin n_fail++; $display("FAIL store_extra addr %h", bus.dp_addr); end
        else begin
          e = q.pop_front();
          if ({bus.dp_addr, bus.dp_din} !== e) begin
            n_fail++; $display("FAIL store_beat got %h/%h exp %h/%h", bus.dp_addr, bus.dp_din, e[17:8], e[7:0]);
          end
        end
      end
      if (bus.done) fin = 1'b1;
    end
    n_chk++; if (!fin) begin n_fail++; $display("FAIL store_timeout done not seen"); end
    n_chk++; if (nwe != 256 || q.size() != 0) begin n_fail++; $display("FAIL store_count got %0d left %0d exp 256 0", nwe, q.size()); end
    n_chk++;
    if ({dpram[10'h100], dpram[10'h101], dpram[10'h104]} !== 24'h00_33_01) begin
      n_fail++; $display("FAIL store_bytes got %h %h %h exp 00 33 01", dpram[10'h100], dpram[10'h101], dpram[10'h104]);
    end
  endtask

  task automatic test_program;
    clr_imem();
    imem[0] = mk_instr(OP_CTRL, 4'hF, 8'h01, 16'h0000);
    imem[1] = mk_instr(OP_WAIT, 4'h0, 8'h05, 16'h0000);
    imem[2] = mk_instr(OP_JUMP, 4'h0, 8'h00, 16'h0004);
    imem[3] = mk_instr(OP_CTRL, 4'hF, 8'h01, 16'h0000);
    run_collect(100);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL prog_timeout done not seen"); end
    n_chk++;
    if ({8'(c_sl), 8'(c_st), 8'(c_sr), 8'(c_sd), 8'(c_ae)} !== {5{8'd1}}) begin
      n_fail++; $display("FAIL prog_strobes got %0d %0d %0d %0d %0d exp 1 each", c_sl, c_st, c_sr, c_sd, c_ae);
    end
    n_chk++; if (c_busy != 13) begin n_fail++; $display("FAIL prog_busy_cycles got %0d exp 13", c_busy); end
    n_chk++; if (c_done_busy != 0 || err_done !== 1'b0) begin n_fail++; $display("FAIL prog_done busy %0d err %b exp 0 0", c_done_busy, err_done); end
    @(negedge clk);
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL prog_done_width got %b exp 0", bus.done); end
  endtask

  task automatic test_clr;
    clr_imem();
    imem[0] = mk_instr(OP_CLR, 4'h7, 8'h00, 16'h0000);
    run_collect(50);
    n_chk++;
    if (timed_out || {8'(c_ar), 8'(c_brt), 8'(c_brl), 8'(c_sl + c_sd)} !== 32'h01_01_01_00) begin
      n_fail++; $display("FAIL clr_strobes got %0d %0d %0d ctrl %0d exp 1 1 1 0", c_ar, c_brt, c_brl, c_sl + c_sd);
    end
    n_chk++; if (c_busy != 4) begin n_fail++; $display("FAIL clr_busy_cycles got %0d exp 4", c_busy); end
  endtask

  task automatic test_illegal(input logic [3:0] op);
    clr_imem();
    imem[0] = mk_instr(op, 4'h0, 8'h00, 16'h0000);
    run_collect(50);
    n_chk++; if (timed_out || c_done != 1 || err_done !== 1'b1) begin n_fail++; $display("FAIL illegal_%h done %0d err %b exp 1 1", op, c_done, err_done); end
    repeat (3) @(negedge clk);
    n_chk++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL illegal_sticky err %b busy %b exp 1 0", bus.err, bus.busy); end
    imem[0] = HALT;
    run_collect(50);
    n_chk++; if (err0 !== 1'b0 || rd0 !== 8'd0) begin n_fail++; $display("FAIL err_clear err %b pc %0d exp 0 0", err0, rd0); end
    n_chk++; if (c_busy != 2 || err_done !== 1'b0) begin n_fail++; $display("FAIL err_clear_run busy %0d err %b exp 2 0", c_busy, err_done); end
  endtask

  task automatic test_start_held;
    int nb = 0;
    clr_imem();
    imem[0] = mk_instr(OP_WAIT, 4'h0, 8'd20, 16'h0000);
    hold_start = 1'b1;
    run_collect(100);
    hold_start = 1'b0;
    n_chk++; if (timed_out || c_busy != 24) begin n_fail++; $display("FAIL start_held busy %0d exp 24", c_busy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nb += int'(bus.busy);
    end
    n_chk++; if (nb != 0) begin n_fail++; $display("FAIL start_at_halt busy cycles %0d exp 0", nb); end
  endtask

`ifdef VPU_SEQ_LOOP_EN
  task automatic test_loop;
    clr_imem();
    imem[0] = mk_instr(OP_CTRL, 4'h1, 8'h00, 16'h0000);
    imem[1] = mk_instr(OP_LOOP, 4'h0, 8'h03, 16'h0000);
    run_collect(100);
    n_chk++; if (timed_out || c_sd != 4 || err_done !== 1'b0) begin n_fail++; $display("FAIL loop_body got %0d err %b exp 4 0", c_sd, err_done); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    hold_start = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = HALT;
    for (int i = 0; i < 1024; i++) dpram[i] = 8'h00;
    for (int i = 0; i < 64; i++) acc[i] = 32'h0;
    test_reset();
    test_load_top();
    test_reset_mid_load();
    test_store();
    test_program();
    test_clr();
    test_illegal(4'hC);
`ifdef VPU_SEQ_LOOP_EN
    test_loop();
`else
    test_illegal(4'h8);
`endif
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
